// File: rtl/lpc_autocorr_if.sv
// Stream bundle for the autocorrelation block: sample input and lag output.
// slave = the lpc_autocorr side, master = the producer/consumer side.
interface lpc_autocorr_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data;
   logic [4:0]  r_idx;
   logic        r_last;

   modport slave (
      input  in_valid, in_data, r_ready,
      output in_ready, r_valid, r_data, r_idx, r_last
   );

   modport master (
      output in_valid, in_data, r_ready,
      input  in_ready, r_valid, r_data, r_idx, r_last
   );
endinterface

// File: rtl/lpc_autocorr.sv
// Frame autocorrelation r[0..ORDER] for the Levinson-Durbin stage.
// Buffers FRAME_LEN signed Q1.15 samples, then runs one shared MAC over each
// lag in turn and streams sat32(sum >>> SHIFT) as Q4.28 words, lag 0 first.
// The sample buffer is a register array read combinationally, so the MAC is
// not pipelined: lag k costs exactly FRAME_LEN-k compute cycles plus one
// output cycle when the consumer is ready.
module lpc_autocorr #(
   parameter int FRAME_LEN = 256,
   parameter int ORDER     = 10,
   parameter int SHIFT     = 10,
   parameter int ACC_W     = 48
) (
   input  logic          clk,
   input  logic          rst,
   lpc_autocorr_if.slave bus,
   output logic          busy
);
   localparam int IDX_W = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUT} state_t;

   state_t                  state, state_nxt;
   logic signed [15:0]      sbuf [FRAME_LEN];
   logic [IDX_W-1:0]        count, n, n_last, lag_addr;
   logic [4:0]              k;
   logic signed [ACC_W-1:0] acc, acc_sum, acc_shr;
   logic signed [31:0]      prod;
   logic [31:0]             sat_word;
   logic [ACC_W-1:31]       acc_hi;
   logic [31:0]             r_data_q;
   logic [4:0]              r_idx_q;
   logic                    r_last_q;
   logic                    in_ready, r_valid;
   logic                    accept, count_last, mac_last, lag_final, out_hs;

   assign bus.in_ready = in_ready;
   assign bus.r_valid  = r_valid;
   assign bus.r_data   = r_data_q;
   assign bus.r_idx    = r_idx_q;
   assign bus.r_last   = r_last_q;

   assign accept     = bus.in_valid && in_ready;
   assign count_last = (count == IDX_W'(FRAME_LEN - 1));
   assign lag_addr   = n + IDX_W'(k);
   assign n_last     = IDX_W'(FRAME_LEN - 1) - IDX_W'(k);
   assign mac_last   = (n == n_last);
   assign lag_final  = (k == 5'(ORDER));
   assign out_hs     = r_valid && bus.r_ready;

   // MAC datapath: sign-extended product into the accumulator, then scale and clamp
   always_comb begin
      prod     = sbuf[n] * sbuf[lag_addr];
      acc_sum  = acc + {{(ACC_W-32){prod[31]}}, prod};
      acc_shr  = acc_sum >>> SHIFT;
      acc_hi   = acc_shr[ACC_W-1:31];
      sat_word = acc_shr[31:0];
      if (!((&acc_hi) || (~|acc_hi))) begin
         sat_word = acc_shr[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:    if (accept && count_last) state_nxt = S_COMPUTE;
         S_COMPUTE: if (mac_last)             state_nxt = S_OUT;
         S_OUT:     if (out_hs)               state_nxt = lag_final ? S_LOAD : S_COMPUTE;
         default:                             state_nxt = S_LOAD;
      endcase
   end

   // Output decode from state
   always_comb begin
      in_ready = 1'b0;
      r_valid  = 1'b0;
      busy     = 1'b0;
      case (state)
         S_LOAD:    in_ready = 1'b1;
         S_COMPUTE: busy     = 1'b1;
         S_OUT: begin
            busy    = 1'b1;
            r_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Sample buffer write; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (accept) sbuf[count] <= bus.in_data;
   end

   // Counters, accumulator and held lag word
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         k        <= '0;
         n        <= '0;
         acc      <= '0;
         r_data_q <= '0;
         r_idx_q  <= '0;
         r_last_q <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (count_last) begin
                     count <= '0;
                     k     <= '0;
                     n     <= '0;
                     acc   <= '0;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               acc <= acc_sum;
               n   <= n + 1'b1;
               if (mac_last) begin
                  n        <= '0;
                  r_data_q <= sat_word;
                  r_idx_q  <= k;
                  r_last_q <= lag_final;
               end
            end
            S_OUT: begin
               if (out_hs && !lag_final) begin
                  k   <= k + 1'b1;
                  n   <= '0;
                  acc <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lpc_autocorr.sv
// Directed bench for lpc_autocorr: expected lag words are queued when a frame
// is sent and checked in order as the DUT hands them over.
`timescale 1ns/1ps
module tb_lpc_autocorr;
   localparam int N   = 256;
   localparam int P   = 10;
   localparam int SH  = 10;
   localparam int NS  = 16;
   localparam int PS  = 2;
   localparam int SHS = 0;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, busy_s;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t sb_s[$];
   logic signed [15:0] frame [N];

   lpc_autocorr_if bus ();
   lpc_autocorr_if sbus ();

   lpc_autocorr #(.FRAME_LEN(N), .ORDER(P), .SHIFT(SH), .ACC_W(48)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy)
   );

   lpc_autocorr #(.FRAME_LEN(NS), .ORDER(PS), .SHIFT(SHS), .ACC_W(48)) dut_sat (
      .clk(clk), .rst(rst), .bus(sbus), .busy(busy_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_lag(input int k, input int len, input int sh);
      longint sum;
      longint v;
      sum = 0;
      for (int i = 0; i < len - k; i++) sum += longint'(frame[i]) * longint'(frame[i+k]);
      v = sum >>> sh;
      if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
      return v[31:0];
   endfunction

   task automatic push_model(input int len, input int order, input int sh, input bit to_sat);
      for (int k = 0; k <= order; k++) begin
         exp_t e;
         e.idx  = 5'(k);
         e.data = model_lag(k, len, sh);
         e.last = (k == order);
         if (to_sat) sb_s.push_back(e);
         else        sb.push_back(e);
      end
   endtask

   task automatic push_const4000();
      for (int k = 0; k <= P; k++) begin
         exp_t e;
         e.idx  = 5'(k);
         e.data = 32'((N - k) << 18);
         e.last = (k == P);
         sb.push_back(e);
      end
   endtask

   task automatic send_frame();
      for (int i = 0; i < N; i++) begin
         int w;
         w = 0;
         bus.in_valid = 1'b1;
         bus.in_data  = frame[i];
         while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) chk("in_ready_timeout", 32'(w), 0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int w;
      w = 0;
      while (sb.size() != 0 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_drain"}, 32'(sb.size()), 0);
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_r_valid"}, 32'(bus.r_valid), 0);
   endtask

   // Scoreboard for the main DUT: sample just before the edge that completes a handshake
   always @(negedge clk) begin : mon_main
      exp_t e;
      #3;
      if (bus.r_valid && bus.r_ready) begin
         chk("main_word_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("r_idx[%0d]", e.idx), 32'(bus.r_idx), 32'(e.idx));
            chk($sformatf("r_data[%0d]", e.idx), bus.r_data, e.data);
            chk($sformatf("r_last[%0d]", e.idx), 32'(bus.r_last), 32'(e.last));
         end
      end
   end

   // Scoreboard for the saturation DUT
   always @(negedge clk) begin : mon_sat
      exp_t e;
      #3;
      if (sbus.r_valid && sbus.r_ready) begin
         chk("sat_word_expected", 32'(sb_s.size() > 0), 1);
         if (sb_s.size() > 0) begin
            e = sb_s.pop_front();
            chk($sformatf("sat_r_idx[%0d]", e.idx), 32'(sbus.r_idx), 32'(e.idx));
            chk($sformatf("sat_r_data[%0d]", e.idx), sbus.r_data, e.data);
            chk($sformatf("sat_r_last[%0d]", e.idx), 32'(sbus.r_last), 32'(e.last));
         end
      end
   end

   initial begin
      int w;
      int cyc;
      logic seen;
      logic [31:0] lag3;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.r_ready   = 1'b1;
      sbus.in_valid = 1'b0;
      sbus.in_data  = '0;
      sbus.r_ready  = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_r_valid", 32'(bus.r_valid), 0);
      chk("rst_r_data", bus.r_data, 0);
      chk("rst_r_idx", 32'(bus.r_idx), 0);
      chk("rst_r_last", 32'(bus.r_last), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 1);

      // All-zero frame
      for (int i = 0; i < N; i++) frame[i] = '0;
      push_model(N, P, SH, 1'b0);
      send_frame();
      drain("zero");

      // Constant 0x4000 with lag-0 latency
      for (int i = 0; i < N; i++) frame[i] = 16'sh4000;
      push_const4000();
      send_frame();
      chk("compute_busy", 32'(busy), 1);
      chk("compute_in_ready", 32'(bus.in_ready), 0);
      cyc = 0;
      while (!bus.r_valid && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("lag0_latency", 32'(cyc), 256);
      drain("const");

      // Alternating sign
      for (int i = 0; i < N; i++) frame[i] = (i % 2 == 0) ? 16'sh4000 : 16'shC000;
      push_model(N, P, SH, 1'b0);
      send_frame();
      drain("alt");

      // Impulse
      for (int i = 0; i < N; i++) frame[i] = '0;
      frame[0] = 16'sh7FFF;
      push_model(N, P, SH, 1'b0);
      send_frame();
      drain("impulse");

      // Backpressure on lag 3, in_valid held high during compute
      for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
      push_model(N, P, SH, 1'b0);
      lag3 = model_lag(3, N, SH);
      bus.r_ready = 1'b0;
      send_frame();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      for (int k = 0; k <= P; k++) begin
         w = 0;
         while (!bus.r_valid && w < 400) begin
            @(negedge clk);
            w++;
         end
         if (w >= 400) chk("bp_r_valid_timeout", 32'(w), 0);
         chk("bp_in_ready_blocked", 32'(bus.in_ready), 0);
         if (k == 3) begin
            repeat (5) begin
               @(negedge clk);
               chk("bp_stall_r_valid", 32'(bus.r_valid), 1);
               chk("bp_stall_r_data", bus.r_data, lag3);
               chk("bp_stall_r_idx", 32'(bus.r_idx), 3);
               chk("bp_stall_in_ready", 32'(bus.in_ready), 0);
            end
         end
         if (k == P) bus.in_valid = 1'b0;
         bus.r_ready = 1'b1;
         @(negedge clk);
         bus.r_ready = 1'b0;
      end
      bus.r_ready = 1'b1;
      drain("bp");

      // Reset during compute of lag 4
      for (int i = 0; i < N; i++) frame[i] = 16'sh4000;
      push_const4000();
      send_frame();
      w = 0;
      while (!(bus.r_valid && bus.r_idx == 5'd3) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("abort_reach_lag3", 32'(w < 2000), 1);
      @(negedge clk);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("abort_r_valid", 32'(bus.r_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_in_ready", 32'(bus.in_ready), 1);
      rst = 1'b0;
      seen = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (bus.r_valid) seen = 1'b1;
      end
      chk("abort_no_more_lags", 32'(seen), 0);
      push_const4000();
      send_frame();
      drain("after_abort");

      // Saturation: SHIFT=0, all samples -1.0
      for (int i = 0; i < NS; i++) frame[i] = 16'sh8000;
      push_model(NS, PS, SHS, 1'b1);
      for (int i = 0; i < NS; i++) begin
         sbus.in_valid = 1'b1;
         sbus.in_data  = frame[i];
         w = 0;
         while (!sbus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) chk("sat_in_ready_timeout", 32'(w), 0);
         @(negedge clk);
      end
      sbus.in_valid = 1'b0;
      w = 0;
      while (sb_s.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("sat_drain", 32'(sb_s.size()), 0);
      @(negedge clk);
      chk("sat_in_ready", 32'(sbus.in_ready), 1);

      chk("main_queue_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lpc_autocorr.md
Name: lpc_autocorr

Overview:
- Upstream neighbour of the Levinson-Durbin recursion. Buffers one analysis frame of signed Q1.15 samples, then computes autocorrelation lags r[0..ORDER].
- Emits each lag as a signed 32-bit Q4.28 word, the r operand the Levinson q/reflection datapath consumes.
- One shared MAC runs sequentially over all lags. Lags are streamed out with valid/ready, lowest lag first.

Parameters:
- FRAME_LEN, 256, samples per frame N; power of two, 16..1024.
- ORDER, 10, highest lag P; 1..31, less than FRAME_LEN.
- SHIFT, 10, arithmetic right shift from the accumulator (Q30 sum) to the output word; default = log2(N)+2, giving Q4.28 mean.
- ACC_W, 48, accumulator width; must be at least 32+log2(N)+1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample
- in_data  in  16  signed Q1.15 sample
- r_valid  out  1  lag word valid
- r_ready  in  1  consumer accepts lag word
- r_data  out  32  signed Q4.28 autocorrelation lag
- r_idx  out  5  lag index k of r_data
- r_last  out  1  high with r_valid when k == ORDER
- busy  out  1  high in COMPUTE or OUT

Behaviour:
- Reset (rst=1 at an edge): state=LOAD, sample count=0, k=0, n=0, acc=0. r_valid=0, r_data=0, r_idx=0, r_last=0, busy=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the frame. Buffer contents are don't-care, no further lag is emitted, and the next accepted sample is x[0].
- LOAD: in_ready=1. A sample is accepted when in_valid&&in_ready and is written to buf[count]; count increments.
  - On accepting sample N-1: next state COMPUTE, k=0, n=0, acc=0, count=0.
- COMPUTE: in_ready=0, busy=1. Each cycle: acc <= acc + x[n]*x[n+k] (full 32-bit signed product, sign-extended to ACC_W); n++.
  - The MAC with n == N-1-k is the last one for lag k. Next state is OUT, with r_data = sat32(acc_final >>> SHIFT), r_idx=k, r_last=(k==ORDER), r_valid=1.
  - Lag k therefore takes exactly N-k COMPUTE cycles; r_valid rises on the edge ending the last MAC.
- sat32: values above 2^31-1 clamp to 0x7FFFFFFF; values below -2^31 clamp to 0x80000000. The shift truncates toward -inf; there is no rounding.
- OUT: r_valid=1. r_data, r_idx and r_last are held stable until r_ready=1; there are no bubbles and no change while stalled.
  - On handshake with k<ORDER: k++, n=0, acc=0, next state COMPUTE, r_valid=0 the next cycle.
  - On handshake with k==ORDER: next state LOAD, r_valid=0, busy=0, in_ready=1 the next cycle.
- Samples arriving outside LOAD are not accepted (in_ready=0). Upstream holds them per valid/ready rules.
- r_data, r_idx and r_last retain their last value when r_valid=0; consumers qualify them with r_valid.
- Total frame compute time with an always-ready consumer: sum over k=0..P of (N-k+1) cycles. For defaults that is 2772 cycles.
- Buffer is an N x 16 register array or inferred RAM. For RAM, read latency must be absorbed without changing the cycle counts above; a 1-cycle read is permitted by pipelining the MAC, adding a fixed 1 cycle per lag, which must be documented in the RTL header.

Test Plan:
- All-zero frame, defaults, r_ready=1 -> 11 words, all r_data=0x00000000, r_idx 0..10, r_last only on idx 10, then in_ready=1.
- Constant x=0x4000 -> r[0]=0x04000000, r[k]=(256-k)*2^18, e.g. r[1]=0x03FC0000, r[10]=0x03D80000; r_valid for lag 0 exactly 256 cycles after COMPUTE entry.
- Alternating x=+0x4000,-0x4000 -> r[0]=0x04000000, r[1]=0xFC040000, r[2]=0x03F80000 (sign (-1)^k).
- Impulse x[0]=0x7FFF, rest 0 -> r[0]=0x000FFFC0, r[1..10]=0. Saturation variant SHIFT=0, all x=0x8000 -> r[0]=0x7FFFFFFF.
- Backpressure: hold r_ready=0 for 5 cycles while lag 3 is presented -> r_valid stays 1, r_data/r_idx unchanged, no lag lost or duplicated; in_valid held high during COMPUTE is not accepted.
- Assert rst for 1 cycle during COMPUTE of lag 4 -> next cycle r_valid=0, busy=0, in_ready=1. A following clean constant-0x4000 frame yields the same values as scenario 2.
